// File: rtl/pbvi_step_sequencer.sv
// Run scheduler for one PBVI value-iteration pass: launches each pipeline stage in
// order, waits for its completion, repeats until convergence or the iteration limit.
module pbvi_step_sequencer #(
  parameter int NUM_STEPS    = 4,
  parameter int ITER_W       = 8,
  parameter int TMO_W        = 8,
  parameter int STEP_TIMEOUT = 64
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic                         abort,
  input  logic [ITER_W-1:0]            max_iter,
  input  logic [NUM_STEPS-1:0]         step_done,
  input  logic                         converged,
  output logic [NUM_STEPS-1:0]         step_en,
  output logic [$clog2(NUM_STEPS)-1:0] cur_step,
  output logic [ITER_W-1:0]            iter_count,
  output logic                         busy,
  output logic                         done,
  output logic                         err_timeout
);

  localparam int CS_W = $clog2(NUM_STEPS);
  localparam logic [CS_W-1:0]  LAST_STEP = CS_W'(NUM_STEPS - 1);
  localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(STEP_TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LAUNCH = 3'd1,
    S_WAIT   = 3'd2,
    S_FINISH = 3'd3,
    S_ERROR  = 3'd4
  } state_e;

  state_e                state_q, state_d;
  logic [CS_W-1:0]       cur_step_q, cur_step_d;
  logic [ITER_W-1:0]     iter_q, iter_d;
  logic [ITER_W-1:0]     limit_q, limit_d;
  logic [TMO_W-1:0]      tmo_q, tmo_d;
  logic [NUM_STEPS-1:0]  step_en_q, step_en_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;

  logic [ITER_W:0]       iter_nxt_s;
  logic [TMO_W-1:0]      tmo_inc_s;
  logic                  cur_done_s;

  assign iter_nxt_s = {1'b0, iter_q} + {{ITER_W{1'b0}}, 1'b1};
  assign tmo_inc_s  = tmo_q + {{(TMO_W-1){1'b0}}, 1'b1};
  assign cur_done_s = step_done[cur_step_q];

  // Next-state and next-output computation; outputs are derived from the next state
  // so every output port comes straight from a flop.
  always_comb begin
    state_d    = state_q;
    cur_step_d = cur_step_q;
    iter_d     = iter_q;
    limit_d    = limit_q;
    tmo_d      = tmo_q;
    err_d      = err_q;

    if (abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            limit_d    = max_iter;
            iter_d     = {ITER_W{1'b0}};
            cur_step_d = {CS_W{1'b0}};
            err_d      = 1'b0;
            state_d    = (max_iter == {ITER_W{1'b0}}) ? S_FINISH : S_LAUNCH;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_LAUNCH: begin
          // The launch cycle itself counts toward the stage's timeout budget.
          tmo_d   = {{(TMO_W-1){1'b0}}, 1'b1};
          state_d = S_WAIT;
        end
        S_WAIT: begin
          if (cur_done_s) begin
            if (cur_step_q != LAST_STEP) begin
              cur_step_d = cur_step_q + {{(CS_W-1){1'b0}}, 1'b1};
              state_d    = S_LAUNCH;
            end else begin
              iter_d = iter_nxt_s[ITER_W] ? iter_q : iter_nxt_s[ITER_W-1:0];
              if (converged || (iter_nxt_s == {1'b0, limit_q})) begin
                state_d = S_FINISH;
              end else begin
                cur_step_d = {CS_W{1'b0}};
                state_d    = S_LAUNCH;
              end
            end
          end else begin
            tmo_d = tmo_inc_s;
            if (tmo_inc_s >= TMO_LIMIT) begin
              err_d   = 1'b1;
              state_d = S_ERROR;
            end else begin
              state_d = S_WAIT;
            end
          end
        end
        S_FINISH: state_d = S_IDLE;
        S_ERROR:  state_d = S_IDLE;
        default:  state_d = S_IDLE;
      endcase
    end

    if (state_d == S_LAUNCH) begin
      step_en_d = NUM_STEPS'(1) << cur_step_d;
    end else begin
      step_en_d = {NUM_STEPS{1'b0}};
    end
    busy_d = (state_d == S_LAUNCH) || (state_d == S_WAIT);
    done_d = (state_d == S_FINISH);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cur_step_q <= {CS_W{1'b0}};
      iter_q     <= {ITER_W{1'b0}};
      limit_q    <= {ITER_W{1'b0}};
      tmo_q      <= {TMO_W{1'b0}};
      step_en_q  <= {NUM_STEPS{1'b0}};
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_step_q <= cur_step_d;
      iter_q     <= iter_d;
      limit_q    <= limit_d;
      tmo_q      <= tmo_d;
      step_en_q  <= step_en_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign step_en     = step_en_q;
  assign cur_step    = cur_step_q;
  assign iter_count  = iter_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign err_timeout = err_q;

endmodule

// File: tb/tb_pbvi_step_sequencer.sv
// Directed bench for pbvi_step_sequencer: a per-cycle vector table plus scripted
// multi-cycle runs driven by a stage responder with fixed latency.
module tb_pbvi_step_sequencer;

  localparam int NS     = 4;
  localparam int ITER_W = 8;
  localparam int TMO_W  = 8;
  localparam int TMO    = 64;
  localparam int BUDGET = 2000;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic             abort;
  logic [ITER_W-1:0] max_iter;
  logic [NS-1:0]    step_done;
  logic             converged;
  logic [NS-1:0]    step_en;
  logic [1:0]       cur_step;
  logic [ITER_W-1:0] iter_count;
  logic             busy;
  logic             done;
  logic             err_timeout;

  pbvi_step_sequencer #(
    .NUM_STEPS(NS), .ITER_W(ITER_W), .TMO_W(TMO_W), .STEP_TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .max_iter(max_iter),
    .step_done(step_done), .converged(converged), .step_en(step_en), .cur_step(cur_step),
    .iter_count(iter_count), .busy(busy), .done(done), .err_timeout(err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic             start;
    logic             abort;
    logic [ITER_W-1:0] max_iter;
    logic [NS-1:0]    step_done;
    logic             converged;
    logic [NS-1:0]    en;
    logic [1:0]       cur;
    logic [ITER_W-1:0] iter;
    logic             busy;
    logic             done;
    logic             err;
  } vec_t;

  vec_t tbl [14];

  int n_cmp = 0;
  int n_bad = 0;

  // results of the last scripted run
  int en_count, ndone, done_cyc, err_cyc, first_en_cyc, en1_cyc, order_bad, timed_out;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic run_seq(input int mi, input int lat, input int conv_at, input int hang_stage,
                         input int abort_stage, input int abort_iter, input int poke_cyc);
    int cnt, finals, cur, cyc, idx;
    bit abort_arm;
    en_count = 0; ndone = 0; done_cyc = -1; err_cyc = -1; first_en_cyc = -1;
    en1_cyc = -1; order_bad = 0; timed_out = 0;
    cnt = -1; finals = 0; cur = 0; abort_arm = 1'b0;
    start = 1'b1; max_iter = ITER_W'(mi);
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    while (1) begin
      if (done) begin ndone++; done_cyc = cyc; end
      if (err_timeout && err_cyc < 0) err_cyc = cyc;
      if (step_en != '0) begin
        idx = 0;
        for (int i = 0; i < NS; i++) if (step_en[i]) idx = i;
        if ((step_en != (NS'(1) << idx)) || (idx != en_count % NS)) order_bad++;
        if (first_en_cyc < 0) first_en_cyc = cyc;
        if (idx == 1 && en1_cyc < 0) en1_cyc = cyc;
        step_done = '0; converged = 1'b0; cur = idx;
        cnt = (idx == hang_stage) ? -1 : lat;
        if (idx == abort_stage && (en_count / NS) == abort_iter) abort_arm = 1'b1;
        en_count++;
      end else if (abort_arm) begin
        abort = 1'b1; abort_arm = 1'b0;
      end else if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          step_done[cur] = 1'b1;
          if (cur == NS - 1) begin
            finals++;
            converged = (finals == conv_at);
          end
        end
      end
      if (cyc == poke_cyc) begin
        start = 1'b1; max_iter = ITER_W'(1);
      end else begin
        start = 1'b0; max_iter = ITER_W'(mi);
      end
      if (!busy) break;
      if (cyc >= BUDGET) begin timed_out = 1; break; end
      @(negedge clk);
      cyc++;
    end
    abort = 1'b0; step_done = '0; converged = 1'b0; start = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (done) ndone++;
      if (step_en != '0) en_count++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int en_seen, busy_seen;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; max_iter = '0; step_done = '0; converged = 1'b0;

    //             start abort max    done     conv  en       cur   iter  busy  done  err
    tbl[0]  = '{1'b0, 1'b0, 8'd0, 4'b0000, 1'b0, 4'b0000, 2'd0, 8'd0, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 1'b1, 8'd5, 4'b0000, 1'b0, 4'b0000, 2'd0, 8'd0, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 1'b0, 8'd0, 4'b0000, 1'b0, 4'b0000, 2'd0, 8'd0, 1'b0, 1'b1, 1'b0};
    tbl[3]  = '{1'b0, 1'b0, 8'd0, 4'b0000, 1'b0, 4'b0000, 2'd0, 8'd0, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{1'b1, 1'b0, 8'd1, 4'b0000, 1'b0, 4'b0001, 2'd0, 8'd0, 1'b1, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 1'b0, 8'd9, 4'b1000, 1'b0, 4'b0000, 2'd0, 8'd0, 1'b1, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, 1'b0, 8'd9, 4'b0001, 1'b0, 4'b0010, 2'd1, 8'd0, 1'b1, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 1'b0, 8'd9, 4'b0001, 1'b0, 4'b0000, 2'd1, 8'd0, 1'b1, 1'b0, 1'b0};
    tbl[8]  = '{1'b0, 1'b0, 8'd9, 4'b0010, 1'b0, 4'b0100, 2'd2, 8'd0, 1'b1, 1'b0, 1'b0};
    tbl[9]  = '{1'b1, 1'b0, 8'd9, 4'b0000, 1'b0, 4'b0000, 2'd2, 8'd0, 1'b1, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 1'b0, 8'd9, 4'b0100, 1'b0, 4'b1000, 2'd3, 8'd0, 1'b1, 1'b0, 1'b0};
    tbl[11] = '{1'b0, 1'b0, 8'd9, 4'b0000, 1'b0, 4'b0000, 2'd3, 8'd0, 1'b1, 1'b0, 1'b0};
    tbl[12] = '{1'b0, 1'b0, 8'd9, 4'b1000, 1'b0, 4'b0000, 2'd3, 8'd1, 1'b0, 1'b1, 1'b0};
    tbl[13] = '{1'b0, 1'b0, 8'd0, 4'b0000, 1'b0, 4'b0000, 2'd3, 8'd1, 1'b0, 1'b0, 1'b0};

    #1;
    check("reset_outputs", int'({step_en, cur_step, iter_count, busy, done, err_timeout}), 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 14; i++) begin
      start = tbl[i].start; abort = tbl[i].abort; max_iter = tbl[i].max_iter;
      step_done = tbl[i].step_done; converged = tbl[i].converged;
      @(negedge clk);
      n_cmp++;
      if ({step_en, cur_step, iter_count, busy, done, err_timeout} !=
          {tbl[i].en, tbl[i].cur, tbl[i].iter, tbl[i].busy, tbl[i].done, tbl[i].err}) begin
        n_bad++;
        $display("FAIL vec%0d: got en=%b cur=%0d iter=%0d busy=%b done=%b err=%b expected en=%b cur=%0d iter=%0d busy=%b done=%b err=%b",
                 i, step_en, cur_step, iter_count, busy, done, err_timeout,
                 tbl[i].en, tbl[i].cur, tbl[i].iter, tbl[i].busy, tbl[i].done, tbl[i].err);
      end
    end
    start = 1'b0; abort = 1'b0; max_iter = '0; step_done = '0; converged = 1'b0;
    @(negedge clk);

    // normal run, 3-cycle stage latency, stray start mid-run
    run_seq(3, 3, 0, -1, -1, -1, 10);
    check("normal_timeout", timed_out, 0);
    check("normal_en_count", en_count, 12);
    check("normal_en_order", order_bad, 0);
    check("normal_iter", int'(iter_count), 3);
    check("normal_done_count", ndone, 1);
    check("normal_done_latency", done_cyc - first_en_cyc, 48);
    check("normal_cur_hold", int'(cur_step), 3);

    // early convergence on the 2nd final-stage completion
    run_seq(10, 2, 2, -1, -1, -1, -1);
    check("conv_en_count", en_count, 8);
    check("conv_iter", int'(iter_count), 2);
    check("conv_done_count", ndone, 1);
    check("conv_en_order", order_bad, 0);

    // abort during stage-2 wait of the second iteration
    run_seq(5, 3, 0, -1, 2, 1, -1);
    check("abort_en_count", en_count, 7);
    check("abort_done_count", ndone, 0);
    check("abort_busy", int'(busy), 0);
    check("abort_iter_hold", int'(iter_count), 1);
    check("abort_cur_hold", int'(cur_step), 2);
    check("abort_err", int'(err_timeout), 0);

    // stage 1 never completes
    run_seq(4, 3, 0, 1, -1, -1, -1);
    check("tmo_latency", err_cyc - en1_cyc, TMO);
    check("tmo_en_count", en_count, 2);
    check("tmo_done_count", ndone, 0);
    check("tmo_err_sticky", int'(err_timeout), 1);
    check("tmo_busy", int'(busy), 0);

    // zero-iteration run also clears the sticky error
    run_seq(0, 3, 0, -1, -1, -1, -1);
    check("zero_en_count", en_count, 0);
    check("zero_done_count", ndone, 1);
    check("zero_done_cycle", done_cyc, 1);
    check("zero_err_cleared", int'(err_timeout), 0);
    check("zero_iter", int'(iter_count), 0);

    // reset mid-run with step_done held high
    start = 1'b1; max_iter = 8'd5;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    step_done = '1;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_mid_outputs", int'({step_en, cur_step, iter_count, busy, done, err_timeout}), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    en_seen = 0; busy_seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (step_en != '0) en_seen++;
      if (busy || done) busy_seen++;
    end
    check("rst_no_en", en_seen, 0);
    check("rst_no_busy", busy_seen, 0);
    step_done = '0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
